// File: rtl/seq_mult_responder.sv
// seq_mult_responder
//   Iterative unsigned shift-add multiplier. It is the responder side of the
//   calc_start/done level handshake. Each RUN cycle consumes STEP_BITS
//   multiplier bits, so one product takes N = WIDTH/STEP_BITS cycles.
//
// Parameters
//   WIDTH      operand width; the result is 2*WIDTH bits wide
//   STEP_BITS  multiplier bits consumed per RUN cycle; must divide WIDTH
//
// Ports
//   CLK         in   clock
//   RST         in   synchronous reset, active-low; aborts any multiply
//   calc_start  in   request level; operands are sampled on the IDLE->RUN edge
//   dataa       in   multiplicand, unsigned
//   datab       in   multiplier, unsigned
//   result      out  exact product dataa*datab (registered)
//   done        out  result valid; held until calc_start drops (registered)
module seq_mult_responder #(
  parameter int WIDTH     = 18,
  parameter int STEP_BITS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               calc_start,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int N     = WIDTH / STEP_BITS;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     result_q, result_d;
  logic              done_q, done_d;

  // The multiplicand is pre-shifted left by STEP_BITS each cycle instead of
  // shifting the partial product by cnt*STEP_BITS, which avoids a barrel
  // shifter. The partial product is therefore always aligned to acc.
  logic [PW-1:0] partial;
  logic [PW-1:0] acc_sum;

  assign partial = mcand_q * PW'(mplier_q[STEP_BITS-1:0]);
  assign acc_sum = acc_q + partial;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (calc_start) begin
          mcand_d  = PW'(dataa);
          mplier_d = datab;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // A dropped request wins over completion, even on the last step;
        // result keeps the previous product.
        if (!calc_start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << STEP_BITS;
          mplier_d = mplier_q >> STEP_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = acc_sum;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        if (!calc_start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_mult_responder.sv
// Bench for seq_mult_responder. Three instances share clock and reset:
// STEP_BITS = 1, 3 and 6 at WIDTH = 18. Stimulus pushes the expected product
// and the sampling edge into a scoreboard queue; a monitor pops an entry on
// every rising done and checks the product and the latency.
module tb_seq_mult_responder;

  localparam int W = 18;

  typedef struct {
    int          k;
    logic [35:0] prod;
    int          t_start;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [2:0]  start;
  logic [W-1:0]   da [3];
  logic [W-1:0]   db [3];
  logic [2*W-1:0] res [3];
  logic [2:0]  done;

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SB = (g == 0) ? 1 : (g == 1) ? 3 : 6;
    seq_mult_responder #(.WIDTH(W), .STEP_BITS(SB)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .calc_start (start[g]),
      .dataa      (da[g]),
      .datab      (db[g]),
      .result     (res[g]),
      .done       (done[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int step_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 6;
  endfunction

  function automatic int lat_of(int k);
    return W / step_of(k);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising done must match the oldest outstanding request
  // for that instance, both in value and in latency.
  logic [2:0] done_prev;
  initial done_prev = '0;
  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k] && !done_prev[k]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].k == k) idx = i;
        if (idx < 0) begin
          check($sformatf("unexpected_done[%0d]", k), 64'd1, 64'd0);
        end else begin
          check($sformatf("product[%0d]", k), 64'(res[k]), 64'(sb[idx].prod));
          check($sformatf("latency[%0d]", k), 64'(cyc - sb[idx].t_start),
                64'(lat_of(k)));
          sb.delete(idx);
        end
      end
    end
    done_prev <= done;
  end

  // Raise calc_start with new operands and register the expectation.
  task automatic issue(int k, logic [W-1:0] x, logic [W-1:0] y, bit expect_it);
    exp_t e;
    @(negedge CLK);
    da[k]    = x;
    db[k]    = y;
    start[k] = 1'b1;
    if (expect_it) begin
      e.k       = k;
      e.prod    = 36'(x) * 36'(y);
      e.t_start = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(int k);
    int i;
    i = 0;
    while (!done[k] && i < 60) begin
      @(negedge CLK);
      i++;
    end
    if (!done[k]) check($sformatf("timeout[%0d]", k), 64'(done[k]), 64'd1);
  endtask

  // Drop calc_start; done must fall exactly one edge later.
  task automatic release_req(int k);
    start[k] = 1'b0;
    @(negedge CLK);
    check($sformatf("done_fall[%0d]", k), 64'(done[k]), 64'd0);
  endtask

  task automatic full_mult(int k, logic [W-1:0] x, logic [W-1:0] y);
    issue(k, x, y, 1'b1);
    @(negedge CLK);
    wait_done(k);
    release_req(k);
  endtask

  initial begin
    logic [35:0] prev;
    logic [W-1:0] x, y;

    n_vec = 0;
    n_err = 0;
    RST   = 1'b0;
    start = '0;
    for (int k = 0; k < 3; k++) begin
      da[k] = '0;
      db[k] = '0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_done[%0d]", k), 64'(done[k]), 64'd0);
      check($sformatf("rst_result[%0d]", k), 64'(res[k]), 64'd0);
    end
    RST = 1'b1;

    // Reference product, hold request for 10 cycles after done.
    issue(0, 18'h08240, 18'h07DC0, 1'b1);
    @(negedge CLK);
    wait_done(0);
    check("ref_product", 64'(res[0]), 64'h03FFAF000);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      da[0] = 18'(i * 77);
      check("hold_done", 64'(done[0]), 64'd1);
      check("hold_result", 64'(res[0]), 64'h03FFAF000);
    end
    release_req(0);

    // Corner operands; the next request is raised right after done falls.
    full_mult(0, 18'h3FFFF, 18'h3FFFF);
    check("max_product", 64'(res[0]), 64'hFFFF80001);
    full_mult(0, 18'h10000, 18'h10000);
    check("pow2_product", 64'(res[0]), 64'h100000000);
    full_mult(0, 18'h00000, 18'h3FFFF);
    check("zero_product", 64'(res[0]), 64'd0);
    full_mult(0, 18'h00ABC, 18'h00123);

    // Abort after 5 RUN cycles: no done, result keeps the old product.
    prev = 36'(18'h00ABC) * 36'(18'h00123);
    issue(0, 18'h1F00F, 18'h2ABCD, 1'b0);
    repeat (5) @(negedge CLK);
    start[0] = 1'b0;
    da[0]    = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_done", 64'(done[0]), 64'd0);
      check("abort_result", 64'(res[0]), 64'(prev));
    end
    full_mult(0, 18'h1F00F, 18'h2ABCD);

    // Reset in the middle of RUN with calc_start still high.
    issue(0, 18'h2468A, 18'h13579, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rstrun_done", 64'(done[0]), 64'd0);
    check("rstrun_result", 64'(res[0]), 64'd0);
    begin
      exp_t e;
      RST       = 1'b1;
      e.k       = 0;
      e.prod    = 36'(18'h2468A) * 36'(18'h13579);
      e.t_start = cyc + 1;
      sb.push_back(e);
    end
    @(negedge CLK);
    wait_done(0);
    release_req(0);

    // Random operands on every instance, with corner values mixed in.
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 0) ? 40 : 200;
      for (int i = 0; i < n; i++) begin
        x = 18'($urandom);
        y = 18'($urandom);
        if ($urandom_range(0, 9) == 0) x = ($urandom_range(0, 1) != 0) ? 18'h3FFFF : 18'h0;
        if ($urandom_range(0, 9) == 0) y = ($urandom_range(0, 1) != 0) ? 18'h3FFFF : 18'h0;
        full_mult(k, x, y);
      end
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
